seg7_scan_mux: RTL and testbench
================================

Name: seg7_scan_mux

Overview:
- Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
- Captures a packed hex value and presents one nibble at a time to the downstream synchronous 7-segment decoder.
- Drives the active-low digit enables, with a blanking window at the start of each digit slot. The window covers the decoder's one-cycle register latency and prevents ghosting.
- Sits directly upstream of the per-digit segment decoder in the display path.

Parameters:
- DIGITS, 4, number of display digits (>=2).
- REFRESH_DIV, 50000, clock cycles per digit slot (>= BLANK_CYCLES+2).
- BLANK_CYCLES, 16, cycles at the start of each slot with all digits off (>=2).

Ports:
- i_clk  input  1  system clock; all state changes on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_load  input  1  when high at a clock edge, capture iv_value into the shadow register.
- iv_value  input  4*DIGITS  packed hex digits; [3:0] = digit 0 (rightmost).
- iv_blank_mask  input  DIGITS  bit n high = digit n kept dark (its slot is still consumed).
- ov_nibble  output  4  registered nibble for the downstream decoder.
- ov_digit_en_n  output  DIGITS  registered, active-low digit enables; at most one bit low.
- ov_frame  output  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.

Behaviour:
- Reset: i_rst_n low immediately clears all registers, regardless of clock.
  - shadow = 0, slot counter = 0, digit index = 0, state = BLANK.
  - ov_nibble = 0, ov_digit_en_n = all ones, ov_frame = 0.
- Reset mid-slot: aborts the scan at once. After release, scanning restarts at digit 0, BLANK, counter 0.
- Shadow capture:
  - i_load high at edge k: shadow = iv_value at k.
  - ov_nibble reflects the new data at edge k+1 if the current index selects it.
  - Loads are allowed mid-slot; no ov_frame synchronisation is required.
  - i_load low: shadow holds its value.
- Slot counter:
  - Increments every cycle, 0..REFRESH_DIV-1.
  - On the edge where it is REFRESH_DIV-1, it wraps to 0 and the index advances (DIGITS-1 wraps to 0).
- ov_nibble: registered every cycle as shadow[4*idx+3 : 4*idx], using the index value after that edge's update.
- State machine (two states):
  - BLANK: all enables high.
    - Transition to SHOW on the edge where the counter goes BLANK_CYCLES-1 -> BLANK_CYCLES.
    - On that same edge, ov_digit_en_n[idx] goes low, unless iv_blank_mask[idx] = 1.
  - SHOW: exactly enable[idx] low (or none if masked). iv_blank_mask is sampled every cycle in SHOW, so a mask change takes effect on the next edge.
    - Transition to BLANK on the counter wrap edge.
    - On that same edge, all enables go high.
- Latency guarantee: ov_nibble is stable at least BLANK_CYCLES-1 cycles before its enable asserts. This covers the one-cycle downstream decoder register.
- ov_frame: high for exactly the one cycle following the wrap edge on which the index changes DIGITS-1 -> 0. It never pulses in the first slot after reset.
- Timing per slot: enable low for REFRESH_DIV-BLANK_CYCLES cycles. Frame period = DIGITS*REFRESH_DIV cycles.
- Simultaneous load and wrap: the new shadow data and the new index both apply. ov_nibble at the next edge shows the new digit from the new data.

Test Plan (DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2 unless noted):
- Reset, then release with i_load=0 -> ov_digit_en_n=4'b1111, ov_nibble=0 through edge 1.
  - en_n=4'b1110 from edge 2 through the edge before the wrap (6 cycles).
  - en_n=4'b1111 at edge 8, 4'b1101 at edge 10.
- i_load pulse with iv_value=16'hA3C5 -> ov_nibble sequence per slot: 5, C, 3, A, 5...
  - ov_frame pulses once every 32 cycles, on the wrap from digit 3 to digit 0.
- iv_blank_mask=4'b0100 -> en_n stays 4'b1111 for the whole digit-2 slot; digits 0, 1, 3 are unaffected; frame period is still 32.
- i_load asserted on the same edge as the slot 1->2 wrap with iv_value=16'h0F00 -> ov_nibble=F on the next edge.
  - en_n=4'b1011 two cycles after the wrap.
- i_rst_n pulled low mid-SHOW of digit 3 (no clock edge) -> outputs go to reset values immediately.
  - After release the scan restarts at digit 0, with the first ov_frame 32 cycles later.
- REFRESH_DIV=20, BLANK_CYCLES=5 -> enable low for 15 cycles per slot.
  - ov_nibble is stable at least 4 cycles before each enable falls.

Source files
------------

// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - time-multiplexed scan controller for a common-anode 7-segment display
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_load         capture iv_value into the shadow register
//   iv_value       packed hex digits, [3:0] = digit 0 (rightmost)
//   iv_blank_mask  bit n high keeps digit n dark (slot still consumed)
//   ov_nibble      registered nibble for the downstream segment decoder
//   ov_digit_en_n  registered active-low digit enables, at most one low
//   ov_frame       one-cycle pulse after the scan wraps from the last digit to digit 0

module seg7_scan_mux #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic [4*DIGITS-1:0]   iv_value,
  input  logic [DIGITS-1:0]     iv_blank_mask,
  output logic [3:0]            ov_nibble,
  output logic [DIGITS-1:0]     ov_digit_en_n,
  output logic                  ov_frame
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [0:0]          state_q, state_d;
  logic [3:0]          nibble_q, nibble_d;
  logic [DIGITS-1:0]   en_n_q, en_n_d;
  logic                frame_q, frame_d;

  logic                wrap;
  logic [DIGITS-1:0]   en_show;

  always_comb begin
    wrap     = (cnt_q == CNT_LAST);
    cnt_d    = wrap ? '0 : cnt_q + 1'b1;

    idx_d = idx_q;
    if (wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    shadow_d = i_load ? iv_value : shadow_q;

    // Nibble follows the post-update index but the pre-update shadow, so a
    // load is visible one edge after capture and a wrap is visible at once.
    nibble_d = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        nibble_d = shadow_q[4*i +: 4];
      end
    end

    // Enable pattern for the current digit; mask is sampled live.
    for (int i = 0; i < DIGITS; i++) begin
      en_show[i] = !((idx_q == IDX_W'(i)) && !iv_blank_mask[i]);
    end

    state_d = state_q;
    en_n_d  = '1;
    if (state_q == ST_BLANK) begin
      if (cnt_q == CNT_SHOW) begin
        state_d = ST_SHOW;
        en_n_d  = en_show;
      end
    end else begin
      if (wrap) begin
        state_d = ST_BLANK;
      end else begin
        en_n_d = en_show;
      end
    end

    frame_d = wrap && (idx_q == IDX_LAST);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      state_q  <= ST_BLANK;
      nibble_q <= 4'h0;
      en_n_q   <= '1;
      frame_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      state_q  <= state_d;
      nibble_q <= nibble_d;
      en_n_q   <= en_n_d;
      frame_q  <= frame_d;
    end
  end

  assign ov_nibble     = nibble_q;
  assign ov_digit_en_n = en_n_q;
  assign ov_frame      = frame_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb/tb_seg7_scan_mux.sv - directed self-checking bench for seg7_scan_mux

module tb_seg7_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  mask = 4'h0;
  logic [3:0]  nibble;
  logic [3:0]  en_n;
  logic        frame;

  logic        load2 = 1'b0;
  logic [15:0] value2 = 16'h0;
  logic [3:0]  mask2 = 4'h0;
  logic [3:0]  nibble2;
  logic [3:0]  en_n2;
  logic        frame2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_scan_mux #(.DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load), .iv_value(value),
    .iv_blank_mask(mask), .ov_nibble(nibble), .ov_digit_en_n(en_n), .ov_frame(frame)
  );

  seg7_scan_mux #(.DIGITS(4), .REFRESH_DIV(20), .BLANK_CYCLES(5)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_load(load2), .iv_value(value2),
    .iv_blank_mask(mask2), .ov_nibble(nibble2), .ov_digit_en_n(en_n2), .ov_frame(frame2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after a posedge with reset released;
  // the next posedge is edge 1.
  task automatic do_reset();
    load = 1'b0; load2 = 1'b0; mask = 4'h0; mask2 = 4'h0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (en_n !== 4'b1111) begin errors++; $display("FAIL reset_en_n: got %b expected 1111", en_n); end
    checks++;
    if (nibble !== 4'h0) begin errors++; $display("FAIL reset_nibble: got %h expected 0", nibble); end
    checks++;
    if (frame !== 1'b0) begin errors++; $display("FAIL reset_frame: got %b expected 0", frame); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 1) begin
        checks++;
        if (en_n !== 4'b1111 || nibble !== 4'h0) begin
          errors++; $display("FAIL first_edge: got en_n=%b nib=%h expected 1111/0", en_n, nibble);
        end
      end else if (e >= 2 && e <= 7) begin
        checks++;
        if (en_n !== 4'b1110) begin errors++; $display("FAIL slot0_show e%0d: got %b expected 1110", e, en_n); end
      end else if (e == 8) begin
        checks++;
        if (en_n !== 4'b1111) begin errors++; $display("FAIL wrap_blank: got %b expected 1111", en_n); end
      end else if (e == 10) begin
        checks++;
        if (en_n !== 4'b1101) begin errors++; $display("FAIL slot1_show: got %b expected 1101", en_n); end
      end
    end
  endtask

  task automatic test_hex_sequence();
    logic [3:0] exp_nib [5];
    int nframes;
    int first_f;
    int second_f;
    exp_nib[0] = 4'h5; exp_nib[1] = 4'hC; exp_nib[2] = 4'h3; exp_nib[3] = 4'hA; exp_nib[4] = 4'h5;
    nframes = 0; first_f = -1; second_f = -1;
    do_reset();
    value = 16'hA3C5;
    load = 1'b1;
    for (int e = 1; e <= 70; e++) begin
      tick();
      load = 1'b0;
      if (frame === 1'b1) begin
        nframes++;
        if (first_f < 0) first_f = e; else if (second_f < 0) second_f = e;
      end
      if ((e % 8) == 4 && e <= 36) begin
        checks++;
        if (nibble !== exp_nib[e/8]) begin
          errors++; $display("FAIL hex_nibble slot%0d: got %h expected %h", e/8, nibble, exp_nib[e/8]);
        end
      end
    end
    checks++;
    if (nframes != 2) begin errors++; $display("FAIL frame_count: got %0d expected 2", nframes); end
    checks++;
    if (first_f != 32 || second_f != 64) begin
      errors++; $display("FAIL frame_edges: got %0d,%0d expected 32,64", first_f, second_f);
    end
  endtask

  task automatic test_blank_mask();
    logic [3:0] exp_en;
    int idx;
    int nframes;
    nframes = 0;
    do_reset();
    mask = 4'b0100;
    for (int e = 1; e <= 40; e++) begin
      tick();
      idx = (e / 8) % 4;
      exp_en = 4'b1111;
      if ((e % 8) >= 2 && idx != 2) exp_en[idx] = 1'b0;
      checks++;
      if (en_n !== exp_en) begin errors++; $display("FAIL mask_en e%0d: got %b expected %b", e, en_n, exp_en); end
      if (frame === 1'b1) nframes++;
      if (e == 32) begin
        checks++;
        if (frame !== 1'b1) begin errors++; $display("FAIL mask_frame: got %b expected 1", frame); end
      end
    end
    checks++;
    if (nframes != 1) begin errors++; $display("FAIL mask_frame_count: got %0d expected 1", nframes); end
    mask = 4'h0;
  endtask

  task automatic test_load_on_wrap();
    do_reset();
    for (int e = 1; e <= 15; e++) tick();
    value = 16'h0F00;
    load = 1'b1;
    tick();
    load = 1'b0;
    checks++;
    if (nibble !== 4'h0) begin errors++; $display("FAIL load_wrap_e16: got %h expected 0", nibble); end
    tick();
    checks++;
    if (nibble !== 4'hF) begin errors++; $display("FAIL load_wrap_nibble: got %h expected F", nibble); end
    checks++;
    if (en_n !== 4'b1111) begin errors++; $display("FAIL load_wrap_blank: got %b expected 1111", en_n); end
    tick();
    checks++;
    if (en_n !== 4'b1011) begin errors++; $display("FAIL load_wrap_en: got %b expected 1011", en_n); end
  endtask

  task automatic test_async_reset();
    int first_f;
    first_f = -1;
    do_reset();
    value = 16'h1234;
    load = 1'b1;
    for (int e = 1; e <= 28; e++) begin
      tick();
      load = 1'b0;
    end
    checks++;
    if (en_n !== 4'b0111 || nibble !== 4'h1) begin
      errors++; $display("FAIL pre_reset_show3: got en_n=%b nib=%h expected 0111/1", en_n, nibble);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (en_n !== 4'b1111 || nibble !== 4'h0 || frame !== 1'b0) begin
      errors++; $display("FAIL async_reset: got en_n=%b nib=%h fr=%b expected 1111/0/0", en_n, nibble, frame);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int e = 1; e <= 33; e++) begin
      tick();
      if (frame === 1'b1 && first_f < 0) first_f = e;
      if (e == 2) begin
        checks++;
        if (en_n !== 4'b1110) begin errors++; $display("FAIL restart_digit0: got %b expected 1110", en_n); end
      end
    end
    checks++;
    if (first_f != 32) begin errors++; $display("FAIL restart_frame: got edge %0d expected 32", first_f); end
  endtask

  task automatic test_long_slot();
    int fall_e;
    int last_chg;
    logic [3:0] prev_en;
    logic [3:0] prev_nib;
    fall_e = -1;
    last_chg = 0;
    do_reset();
    value2 = 16'h4321;
    load2 = 1'b1;
    tick();
    load2 = 1'b0;
    prev_en = en_n2;
    prev_nib = nibble2;
    for (int e = 2; e <= 80; e++) begin
      tick();
      if (nibble2 !== prev_nib) last_chg = e;
      if (prev_en === 4'b1111 && en_n2 !== 4'b1111) begin
        fall_e = e;
        if (e > 20) begin
          checks++;
          if (e - last_chg < 4) begin
            errors++; $display("FAIL nibble_setup e%0d: got %0d cycles expected >=4", e, e - last_chg);
          end
        end
      end
      if (prev_en !== 4'b1111 && en_n2 === 4'b1111) begin
        checks++;
        if (e - fall_e != 15) begin
          errors++; $display("FAIL enable_width e%0d: got %0d expected 15", e, e - fall_e);
        end
      end
      prev_en = en_n2;
      prev_nib = nibble2;
    end
  endtask

  initial begin
    test_reset();
    test_hex_sequence();
    test_blank_mask();
    test_load_on_wrap();
    test_async_reset();
    test_long_slot();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
